// File: rtl/alu_core_if.sv
// Request/response bundle between an ALU client (master) and alu_core (slave).
interface alu_core_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             dec_mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             err;

  modport master (
    output start, op, a, b, carry_in, dec_mode,
    input  busy, done, result, flags, err
  );

  modport slave (
    input  start, op, a, b, carry_in, dec_mode,
    output busy, done, result, flags, err
  );
endinterface

// File: rtl/alu_core.sv
// Multi-cycle ALU: binary/BCD add-sub, logic, shift/rotate, inc/dec, compare.
// Flags are {N,V,Z,C}; result/flags commit on the single-cycle done pulse.
module alu_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       phi1,
  input  logic       reset_n,
  alu_core_if.slave  bus
);
  localparam int unsigned MSB     = WIDTH - 1;
  localparam int unsigned NIBBLES = WIDTH / 4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BCD, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_ASL = 4'd5, OP_LSR = 4'd6, OP_ROL = 4'd7,
    OP_ROR = 4'd8, OP_INC = 4'd9, OP_DEC = 4'd10, OP_CMP = 4'd11
  } op_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d, dec_q, dec_d;
  logic [WIDTH-1:0] stg_res_q, stg_res_d;
  logic [3:0]       stg_flags_q, stg_flags_d;
  logic             stg_wres_q, stg_wres_d, stg_err_q, stg_err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [WIDTH:0]   sum_add, sum_sub;
  logic             v_add, v_sub;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_wres, alu_err;
  logic [WIDTH-1:0] bcd_res;
  logic             bcd_c;
  logic [4:0]       nib_s;
  logic             nib_c;

  assign sum_add = {1'b0, a_q} + {1'b0, b_q}  + {{WIDTH{1'b0}}, cin_q};
  assign sum_sub = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, cin_q};
  assign v_add   = (a_q[MSB] == b_q[MSB])  && (sum_add[MSB] != a_q[MSB]);
  assign v_sub   = (a_q[MSB] == ~b_q[MSB]) && (sum_sub[MSB] != a_q[MSB]);

  always_comb begin
    alu_res  = '0;
    alu_c    = flags_q[0];
    alu_v    = flags_q[2];
    alu_wres = 1'b1;
    alu_err  = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum_add[MSB:0]; alu_c = sum_add[WIDTH]; alu_v = v_add; end
      OP_SUB: begin alu_res = sum_sub[MSB:0]; alu_c = sum_sub[WIDTH]; alu_v = v_sub; end
      OP_CMP: begin alu_res = sum_sub[MSB:0]; alu_c = sum_sub[WIDTH]; alu_wres = 1'b0; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_ASL: begin alu_res = {a_q[MSB-1:0], 1'b0};  alu_c = a_q[MSB]; end
      OP_LSR: begin alu_res = {1'b0, a_q[MSB:1]};    alu_c = a_q[0];   end
      OP_ROL: begin alu_res = {a_q[MSB-1:0], cin_q}; alu_c = a_q[MSB]; end
      OP_ROR: begin alu_res = {cin_q, a_q[MSB:1]};   alu_c = a_q[0];   end
      OP_INC: alu_res = a_q + WIDTH'(1);
      OP_DEC: alu_res = a_q - WIDTH'(1);
      default: begin alu_wres = 1'b0; alu_err = 1'b1; end
    endcase
  end

  // Decimal adjust recomputed nibble by nibble from the latched operands so the
  // adjusted carry (ADD) or no-borrow (SUB) ripples into the next nibble.
  always_comb begin
    bcd_res = '0;
    nib_s   = '0;
    nib_c   = cin_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (op_q == OP_SUB) begin
        nib_s = {1'b0, a_q[4*i +: 4]} - {1'b0, b_q[4*i +: 4]} - {4'b0, ~nib_c};
        if (nib_s[4]) begin
          nib_s = nib_s - 5'd6;
          nib_c = 1'b0;
        end else begin
          nib_c = 1'b1;
        end
      end else begin
        nib_s = {1'b0, a_q[4*i +: 4]} + {1'b0, b_q[4*i +: 4]} + {4'b0, nib_c};
        if (nib_s > 5'd9) begin
          nib_s = nib_s + 5'd6;
          nib_c = 1'b1;
        end else begin
          nib_c = 1'b0;
        end
      end
      bcd_res[4*i +: 4] = nib_s[3:0];
    end
    bcd_c = nib_c;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    dec_d       = dec_q;
    stg_res_d   = stg_res_q;
    stg_flags_d = stg_flags_q;
    stg_wres_d  = stg_wres_q;
    stg_err_d   = stg_err_q;
    result_d    = result_q;
    flags_d     = flags_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          cin_d   = bus.carry_in;
          dec_d   = bus.dec_mode;
          busy_d  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        stg_res_d   = alu_res;
        stg_flags_d = {alu_res[MSB], alu_v, alu_res == '0, alu_c};
        stg_wres_d  = alu_wres;
        stg_err_d   = alu_err;
        if (dec_q && (op_q == OP_ADD || op_q == OP_SUB)) begin
          busy_d  = 1'b1;
          state_d = S_BCD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_BCD: begin
        // V keeps the binary (pre-adjust) value staged in EXEC.
        stg_res_d   = bcd_res;
        stg_flags_d = {bcd_res[MSB], stg_flags_q[2], bcd_res == '0, bcd_c};
        state_d     = S_DONE;
      end
      default: begin
        if (!stg_err_q) begin
          flags_d = stg_flags_q;
          if (stg_wres_q) result_d = stg_res_q;
        end
        done_d  = 1'b1;
        err_d   = stg_err_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      dec_q       <= 1'b0;
      stg_res_q   <= '0;
      stg_flags_q <= '0;
      stg_wres_q  <= 1'b0;
      stg_err_q   <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      dec_q       <= dec_d;
      stg_res_q   <= stg_res_d;
      stg_flags_q <= stg_flags_d;
      stg_wres_q  <= stg_wres_d;
      stg_err_q   <= stg_err_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (WIDTH=8): directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_core;
  logic phi1    = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  logic [7:0] m_res;
  logic       m_n, m_v, m_z, m_c;

  alu_core_if #(.WIDTH(8)) bus ();

  alu_core #(.WIDTH(8)) dut (
    .phi1    (phi1),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 phi1 = ~phi1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int d2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2d(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int sgn(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  task automatic set_res(input int r);
    logic [31:0] rv;
    rv    = r;
    m_res = rv[7:0];
    m_n   = rv[7];
    m_z   = (rv[7:0] == 8'h00);
  endtask

  // Reference model: signed/unsigned integer arithmetic and decimal values.
  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic dec, output logic e);
    int s, sv, r, nb;
    logic [31:0] tv;
    e  = 1'b0;
    nb = cin ? 0 : 1;
    case (op)
      4'd0: begin
        sv  = sgn(a) + sgn(b) + int'(cin);
        m_v = (sv > 127) || (sv < -128);
        if (dec) begin
          s = d2i(a) + d2i(b) + int'(cin);
          m_c = (s >= 100);
          set_res(int'(i2d(s % 100)));
        end else begin
          s = int'(a) + int'(b) + int'(cin);
          m_c = (s > 255);
          set_res(s % 256);
        end
      end
      4'd1: begin
        sv  = sgn(a) - sgn(b) - nb;
        m_v = (sv > 127) || (sv < -128);
        if (dec) begin
          s = d2i(a) - d2i(b) - nb;
          m_c = (s >= 0);
          set_res(int'(i2d(s < 0 ? s + 100 : s)));
        end else begin
          s = int'(a) - int'(b) - nb;
          m_c = (s >= 0);
          set_res(s & 255);
        end
      end
      4'd2: set_res(int'(a & b));
      4'd3: set_res(int'(a | b));
      4'd4: set_res(int'(a ^ b));
      4'd5: begin m_c = a[7]; set_res((int'(a) * 2) % 256); end
      4'd6: begin m_c = a[0]; set_res(int'(a) / 2); end
      4'd7: begin m_c = a[7]; set_res((int'(a) * 2) % 256 + int'(cin)); end
      4'd8: begin m_c = a[0]; set_res(int'(a) / 2 + (cin ? 128 : 0)); end
      4'd9:  set_res((int'(a) + 1) % 256);
      4'd10: set_res((int'(a) + 255) % 256);
      4'd11: begin
        s   = int'(a) - int'(b) - nb;
        m_c = (s >= 0);
        tv  = s & 255;
        m_n = tv[7];
        m_z = (tv[7:0] == 8'h00);
      end
      default: e = 1'b1;
    endcase
  endtask

  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic dec, input bit restart);
    logic ee;
    int   lat;
    model(op, a, b, cin, dec, ee);
    lat = (dec && (op == 4'd0 || op == 4'd1)) ? 3 : 2;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    bus.dec_mode = dec;
    bus.start    = 1'b1;
    @(posedge phi1); #1;
    bus.start    = restart;
    bus.op       = restart ? 4'd0 : 4'($urandom);
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.carry_in = 1'($urandom);
    bus.dec_mode = 1'($urandom);
    chk("busy_after_start", bus.busy, 1);
    chk("done_early", bus.done, 0);
    for (int k = 1; k < lat; k++) begin
      @(posedge phi1); #1;
      bus.start = 1'b0;
      chk("done_early", bus.done, 0);
      chk("busy_mid", bus.busy, (k < lat - 1) ? 1 : 0);
    end
    @(posedge phi1); #1;
    bus.start = 1'b0;
    chk("done", bus.done, 1);
    chk("err", bus.err, ee);
    chk("result", bus.result, m_res);
    chk("flags", bus.flags, {m_n, m_v, m_z, m_c});
    chk("busy_at_done", bus.busy, 0);
    for (int k = 0; k < (restart ? 3 : 1); k++) begin
      @(posedge phi1); #1;
      chk("done_single", bus.done, 0);
    end
  endtask

  task automatic do_reset(input logic with_start);
    reset_n   = 1'b0;
    bus.start = with_start;
    @(posedge phi1); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", bus.flags, 0);
    reset_n   = 1'b1;
    bus.start = 1'b0;
    m_res = 8'h00; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_c = 1'b0;
    @(posedge phi1); #1;
    chk("start_lost_in_reset", bus.busy, 0);
  endtask

  initial begin
    logic [3:0] rop;
    logic [7:0] ra, rb;
    logic       rdec;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.carry_in = 1'b0; bus.dec_mode = 1'b0;
    repeat (2) @(posedge phi1);
    #1;
    do_reset(1'b0);

    do_op(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
    chk("add_50_50_result", bus.result, 8'hA0);
    chk("add_50_50_flags", bus.flags, 4'b1100);

    do_op(4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("sub_0_1_result", bus.result, 8'hFF);
    chk("sub_0_1_flags", bus.flags, 4'b1000);
    do_op(4'd11, 8'h10, 8'h10, 1'b1, 1'b0, 1'b0);
    chk("cmp_keeps_result", bus.result, 8'hFF);
    chk("cmp_flags", bus.flags, 4'b0011);

    do_op(4'd0, 8'h58, 8'h46, 1'b1, 1'b1, 1'b0);
    chk("bcd_add_result", bus.result, 8'h05);
    chk("bcd_add_c", bus.flags[0], 1);

    do_op(4'd8, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("ror_result", bus.result, 8'h80);
    chk("ror_nc", {bus.flags[3], bus.flags[0]}, 2'b11);
    do_op(4'd9, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("inc_wrap_result", bus.result, 8'h00);
    chk("inc_wrap_zc", {bus.flags[1], bus.flags[0]}, 2'b11);
    do_op(4'd10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("dec_wrap_result", bus.result, 8'hFF);

    do_op(4'd2, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1);
    do_op(4'hE, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    chk("illegal_keeps_result", bus.result, 8'h0C);

    do_op(4'd1, 8'h10, 8'h01, 1'b1, 1'b1, 1'b0);
    chk("bcd_sub_result", bus.result, 8'h09);

    // Reset while the decimal adjust is pending.
    bus.op = 4'd0; bus.a = 8'h58; bus.b = 8'h46; bus.carry_in = 1'b1;
    bus.dec_mode = 1'b1; bus.start = 1'b1;
    @(posedge phi1); #1;
    bus.start = 1'b0;
    @(posedge phi1); #1;
    chk("in_bcd_busy", bus.busy, 1);
    reset_n = 1'b0;
    @(posedge phi1); #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_flags", bus.flags, 0);
    reset_n = 1'b1;
    m_res = 8'h00; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge phi1); #1;
      chk("abort_no_done", bus.done, 0);
    end

    do_op(4'd4, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
    do_reset(1'b1);

    for (int i = 0; i < 150; i++) begin
      rop  = 4'($urandom_range(0, 15));
      rdec = 1'($urandom_range(0, 1));
      if (rdec) begin
        ra = i2d(int'($urandom_range(0, 99)));
        rb = i2d(int'($urandom_range(0, 99)));
      end else begin
        ra = 8'($urandom);
        rb = 8'($urandom);
      end
      do_op(rop, ra, rb, 1'($urandom), rdec, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be a multiple of 4 and at least 4.
REQ-002 phi1  input  1  clock; all state SHALL update on the rising edge of phi1.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 INC, 10 DEC, 11 CMP; 12-15 illegal.
REQ-006 a, b  input  WIDTH  operands.
REQ-007 carry_in  input  1  carry/borrow-not in; rotate fill bit.
REQ-008 dec_mode  input  1  BCD mode; affects ADD/SUB only.
REQ-009 busy  output  1  high in EXEC and BCD states.
REQ-010 done  output  1  single-cycle pulse; result/flags valid.
REQ-011 result  output  WIDTH  registered result, held until next done.
REQ-012 flags  output  4  registered {N,V,Z,C}, held until next done.
REQ-013 err  output  1  high with done when op was illegal.

Function
REQ-014 FSM states IDLE, EXEC, BCD, DONE; IDLE -> EXEC when start=1, else stay.
REQ-015 On IDLE->EXEC the block SHALL latch op, a, b, carry_in, dec_mode; later input changes SHALL NOT affect the operation.
REQ-016 EXEC -> BCD when latched dec_mode=1 and op is ADD or SUB; otherwise EXEC -> DONE.
REQ-017 BCD -> DONE unconditionally; DONE -> IDLE unconditionally.
REQ-018 Latency: start sampled at edge N; done=1 after edge N+2 (binary) or N+3 (decimal) for exactly one cycle.
REQ-019 start while not in IDLE SHALL be ignored, not queued.
REQ-020 ADD: {C,res} = a + b + carry_in, WIDTH+1 bits; SUB/CMP: {C,res} = a + ~b + carry_in (C=1 means no borrow).
REQ-021 V for ADD/SUB = operands (b inverted for SUB) share MSB and res MSB differs; CMP, logic, shift, INC, DEC SHALL leave V at its previous value.
REQ-022 AND/OR/XOR: bitwise a op b; C and V unchanged.
REQ-023 ASL: res = a<<1, C = a[MSB]; LSR: res = a>>1, C = a[0]; ROL: fill carry_in at LSB, C = a[MSB]; ROR: fill carry_in at MSB, C = a[0]; b ignored.
REQ-024 INC/DEC: res = a±1 modulo 2^WIDTH, wrap 0xFF->0x00 and 0x00->0xFF (WIDTH=8); C unchanged.
REQ-025 CMP: result output SHALL retain its previous value; N, Z, C SHALL be updated from a - b.
REQ-026 N = res[MSB], Z = (res==0) for every legal op; Z and N computed on the final, post-adjust value.
REQ-027 BCD ADD: per nibble, LSB-first, add 6 if nibble>9 or nibble carried; C = carry out of top nibble after adjust.
REQ-028 BCD SUB: per nibble, subtract 6 where the nibble borrowed; C = no borrow out of top nibble.
REQ-029 V in BCD mode SHALL be the binary (pre-adjust) V.
REQ-030 Non-BCD operands (nibble >9) in BCD mode: apply REQ-027/028 rules unchanged; no error.
REQ-031 Illegal op: err=1 with done, result and flags unchanged; err SHALL be 0 on every other done.

Reset
REQ-032 reset_n=0 at an edge SHALL force state IDLE, busy=0, done=0, err=0, result=0, flags=0 in that cycle.
REQ-033 Reset in EXEC or BCD SHALL abort the operation; no done SHALL follow.
REQ-034 reset_n=0 together with start=1 SHALL take priority; start is lost.

Verification
REQ-035 ADD a=0x50 b=0x50 cin=0 -> done at N+2, result=0xA0, flags N=1 V=1 Z=0 C=0.
REQ-036 SUB a=0x00 b=0x01 cin=1 -> result=0xFF, N=1 Z=0 C=0 V=0; then CMP a=0x10 b=0x10 -> Z=1 C=1, result stays 0xFF.
REQ-037 dec_mode=1 ADD a=0x58 b=0x46 cin=1 -> done at N+3 (not N+2), result=0x05, C=1.
REQ-038 ROR a=0x01 cin=1 -> result=0x80, C=1, N=1; INC a=0xFF -> result=0x00, Z=1, C unchanged.
REQ-039 start re-asserted at N+1 during busy -> ignored, exactly one done; op=0xE -> done with err=1, result/flags unchanged.
REQ-040 reset_n=0 while in BCD -> next cycle busy=0, result=0x00, flags=0; no done pulse observed.
